// File: rtl/cpu_pkg.sv
// Shared definitions for the multiply/divide unit: default datapath width,
// op encodings seen on the op port, and the sequencer state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_ST_IDLE  = 2'd0,
    MD_ST_CALC  = 2'd1,
    MD_ST_FIXUP = 2'd2
  } md_state_e;

  // True for the four ops that run through the iterative datapath.
  function automatic logic md_op_is_arith(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath.
// Ports:
//   clk, reset      clock and async active-high reset
//   load            capture operand magnitudes and sign flags
//   step            perform one shift-add (mul) or shift-subtract (div) iteration
//   is_div          1 = divide, 0 = multiply (sampled on load)
//   is_signed       1 = treat a/b as two's complement (sampled on load)
//   a, b            multiplicand/dividend and multiplier/divisor
//   res_hi, res_lo  sign-corrected result: product, or remainder/quotient
import cpu_pkg::*;

module muldiv_iter #(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic         is_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  // acc holds {partial product, multiplier} for mul, {remainder, quotient} for div.
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic           div_q, div_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           divz_q, divz_d;

  logic [W-1:0]   a_mag, b_mag, quo, rem;
  logic [W:0]     sum, rem_sh, diff;
  logic [2*W-1:0] prod;

  always_comb begin
    // 0x80..0 negates to itself, which read unsigned is exactly 2^(W-1).
    a_mag  = (is_signed && a[W-1]) ? (~a + 1'b1) : a;
    b_mag  = (is_signed && b[W-1]) ? (~b + 1'b1) : b;
    sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
    diff   = rem_sh - {1'b0, opnd_q};

    acc_d     = acc_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;

    if (load) begin
      acc_d     = {{W{1'b0}}, a_mag};
      opnd_d    = b_mag;
      div_d     = is_div;
      neg_quo_d = is_signed && (a[W-1] ^ b[W-1]);
      neg_rem_d = is_signed && a[W-1];
      divz_d    = is_div && (b == '0);
    end else if (step) begin
      if (div_q) begin
        // diff[W] set means the trial subtract went negative: restore.
        acc_d = diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                        : {diff[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        // The add carry lands in the top bit as the accumulator shifts right.
        acc_d = acc_q[0] ? {sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
      end
    end
  end

  always_comb begin
    rem    = acc_q[2*W-1:W];
    quo    = acc_q[W-1:0];
    prod   = neg_quo_q ? (~acc_q + 1'b1) : acc_q;
    res_hi = prod[2*W-1:W];
    res_lo = prod[W-1:0];
    if (div_q) begin
      // A zero divisor leaves the remainder at |a|, so the sign fix returns a itself.
      res_lo = divz_q ? '1 : (neg_quo_q ? (~quo + 1'b1) : quo);
      res_hi = neg_rem_q ? (~rem + 1'b1) : rem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, reset            clock and async active-high reset
//   start, op             issue request (MULT/MULTU/DIV/DIVU/MTHI/MTLO), taken only when idle
//   operand_a, operand_b  rs / rt values
//   flush                 squash in-flight op and any same-cycle start
//   busy                  op in progress, HI/LO not yet valid
//   done                  one-cycle pulse when HI/LO take a new result
//   hi, lo                HI/LO registers
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here directly
// CALC  | XLEN iterations, counter runs down to zero
// FIXUP | apply signs, write HI/LO, pulse done
import cpu_pkg::*;

module muldiv_hilo_unit #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic            load, step, is_div, is_signed;
  logic [XLEN-1:0] it_hi, it_lo;

  assign is_div    = (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  assign is_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);

  muldiv_iter #(.W(XLEN)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .is_div    (is_div),
    .is_signed (is_signed),
    .a         (operand_a),
    .b         (operand_b),
    .res_hi    (it_hi),
    .res_lo    (it_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      MD_ST_IDLE: begin
        if (start && !flush) begin
          if (md_op_is_arith(op)) begin
            load    = 1'b1;
            cnt_d   = CW'(XLEN - 1);
            state_d = MD_ST_CALC;
            busy_d  = 1'b1;
          end else if (op == MD_OP_MTHI) begin
            hi_d = operand_a;
          end else if (op == MD_OP_MTLO) begin
            lo_d = operand_a;
          end
        end
      end
      MD_ST_CALC: begin
        if (flush) begin
          state_d = MD_ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) begin
            state_d = MD_ST_FIXUP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      MD_ST_FIXUP: begin
        state_d = MD_ST_IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          hi_d   = it_hi;
          lo_d   = it_lo;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = MD_ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: behavioural HI/LO model with a latency countdown,
// compared every cycle, plus directed cases with literal expectations.
module tb_muldiv_hilo_unit;

  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [XL-1:0] operand_a = '0;
  logic [XL-1:0] operand_b = '0;
  logic          busy, done;
  logic [XL-1:0] hi, lo;

  muldiv_hilo_unit #(.XLEN(XL)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from integer arithmetic.
  function automatic void ref_result(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] rh,
                                     output logic [31:0] rl);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    rh = '0;
    rl = '0;
    case (o)
      3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      3'd2: begin
        if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
        else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      end
      3'd3: begin
        if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
        else begin uq = ua / ub; ur = ua % ub; rl = uq[31:0]; rh = ur[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // Model: an accepted arithmetic op completes XL+1 edges after the accepting edge.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  int          m_left = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (flush) m_busy = 1'b0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0; m_done = 1'b1; m_hi = r_hi; m_lo = r_lo;
          end
        end
      end else if (start && !flush) begin
        if (op <= 3'd3) begin
          ref_result(op, operand_a, operand_b, r_hi, r_lo);
          m_busy = 1'b1;
          m_left = XL + 1;
        end else if (op == 3'd4) m_hi = operand_a;
        else if (op == 3'd5) m_lo = operand_a;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  // All tasks below are entered and left at a falling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic run_arith(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    issue(o, a, b);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd34);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    chk({name, "_model_hi"}, m_hi, eh);
    chk({name, "_model_lo"}, m_lo, el);
  endtask

  task automatic run_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    ref_result(o, a, b, eh, el);
    run_arith("rand_op", o, a, b, eh, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_arith("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_arith("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_arith("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_arith("divu_zero", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_arith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_arith("div_zero_s", 3'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Flush mid-MULT, with an ignored start while busy.
    issue(3'd0, 32'd5, 32'd6);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd5; operand_a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'h0);
    repeat (40) @(negedge clk);
    chk("flush_hi", hi, 32'hFFFF_FFF0);
    chk("flush_lo", lo, 32'hFFFF_FFFF);

    // MTHI / MTLO back to back, then start+flush.
    start = 1'b1; op = 3'd4; operand_a = 32'h1234;
    @(negedge clk);
    op = 3'd5; operand_a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234);
    chk("mtlo_lo", lo, 32'h5678);
    start = 1'b1; op = 3'd4; operand_a = 32'hFFFF; flush = 1'b1;
    @(negedge clk);
    op = 3'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("sflush_hi", hi, 32'h1234);
    chk("sflush_busy", 32'(busy), 32'h0);

    // Reset in the middle of a DIVU.
    issue(3'd3, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: each run_arith issues in the previous op's done cycle.
    run_model(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    run_model(3'd2, 32'h8765_4321, 32'h0000_1234);
    run_model(3'd3, 32'hFFFF_FFFF, 32'h0000_0003);
    for (int i = 0; i < 24; i++) run_model(3'($urandom_range(0, 3)), pick(), pick());

    // Free-running random traffic including flushes and reserved ops.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op = 3'($urandom_range(0, 7));
      operand_a = pick();
      operand_b = pick();
      flush = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
